boot_sequencer: RTL and testbench
=================================

# boot_sequencer

Top-level boot controller for the core. It owns the single instruction-memory write/read port and gives it to the UART program loader during boot and to the CPU fetch stage during execution. It sequences IDLE → LOAD → START → RUN → HALT, detects end of program, latches the entry PC reported by the loader, and releases the CPU. It sits between `program_loader`, the instruction BRAM and the CPU core.

## Interface
- `ADDR_W`, default 16: instruction memory address width (words).
- `MEM_DEPTH`, default 16384: number of instruction words.
- `END_WORD`, default 32'hFFFF_FFFF: loaded word that terminates the program image.
- `START_DELAY`, default 4: cycles held in START before the CPU is released.

Ports:
- `CLK` in 1: single clock, rising edge.
- `INITIALIZE` in 1: asynchronous, active-high reset.
- `start` in 1: begin a load (level sampled in IDLE/HALT).
- `needed` out 1: enables the loader. High only in LOAD.
- `ld_we` in 1: loader word-write strobe, one cycle per word.
- `ld_addr` in ADDR_W: loader word address.
- `ld_data` in 32: loader word data.
- `pc_init` in 32: entry PC from the loader.
- `cpu_fetch_en` in 1: CPU read request.
- `cpu_fetch_addr` in ADDR_W: CPU read address.
- `cpu_halt` in 1: CPU requests stop.
- `mem_en` out 1: memory port enable.
- `mem_we` out 1: memory port write enable.
- `mem_addr` out ADDR_W: memory port address.
- `mem_wdata` out 32: memory port write data.
- `cpu_run` out 1: CPU may execute. Low holds the CPU in reset.
- `cpu_pc` out 32: latched start PC.
- `words_loaded` out ADDR_W+1: count of words written in the last load.
- `load_error` out 1: sticky overflow flag.

## Operation
- States: IDLE, LOAD, START, RUN, HALT.
- **IDLE**
  - Memory port idle; `cpu_run`=0.
  - `start`=1 → LOAD. Entering LOAD clears `words_loaded` and `load_error`.
- **LOAD**
  - `needed`=1.
  - Each `ld_we` forwards `ld_addr`/`ld_data` to the memory port with `mem_we`=`mem_en`=1, and increments `words_loaded`.
  - `ld_we` with `ld_data`==END_WORD → the word is still written, then → START.
  - `ld_we` with `ld_addr` ≥ MEM_DEPTH → no write, `load_error`=1, → HALT.
  - CPU fetches are ignored.
- **START**
  - On entry, latch `cpu_pc` ← `pc_init`.
  - Stay START_DELAY cycles so the last write retires, then → RUN.
- **RUN**
  - `cpu_run`=1.
  - Memory port follows `cpu_fetch_en`/`cpu_fetch_addr` with `mem_we`=0.
  - Loader strobes are ignored.
  - `cpu_halt`=1 → HALT.
- **HALT**
  - `cpu_run`=0; port idle.
  - `start`=1 → LOAD (reload). Memory is not cleared.
- Simultaneous `ld_we` with END_WORD at an out-of-range address: the error path wins → HALT.
- `cpu_halt` and `start` in the same RUN cycle: `cpu_halt` wins; `start` is evaluated in HALT on the next cycle.
- `words_loaded` saturates at MEM_DEPTH.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE
  - `needed`, `mem_en`, `mem_we`, `cpu_run`, `load_error` = 0
  - `mem_addr`, `mem_wdata`, `cpu_pc`, `words_loaded` = 0
- Latencies:
  - Loader write: `ld_we` at cycle N → `mem_we` at N+1.
  - CPU fetch: `cpu_fetch_en` at N → `mem_en` with address at N+1. The CPU accounts for this extra cycle plus BRAM read latency.
  - `start` sampled at N → `needed`=1 at N+1.
  - END_WORD write at N → START at N+1 → `cpu_run`=1 at N+1+START_DELAY+1.
  - `cpu_halt` at N → `cpu_run`=0 at N+1.
- `INITIALIZE` asserted mid-LOAD or mid-RUN: all outputs drop to reset values asynchronously. Any in-flight write is abandoned and no partial state survives.
- `INITIALIZE` deassertion is synchronized externally. The block has no internal reset synchronizer.

## Structure
- Shared package `boot_pkg`:
  - `boot_state_t` enum (IDLE, LOAD, START, RUN, HALT)
  - `END_WORD`
  - default `ADDR_W` / `MEM_DEPTH`
- One sub-module, `imem_port_mux`: a registered 2:1 selector of loader write vs. CPU fetch, driven by a one-hot owner select from the FSM.
- FSM, delay counter and word counter stay in `boot_sequencer`.

## Test plan
- **Reset mid-load:** reset, `start`, load 3 words at addresses 0..2 (last = 32'hFFFF_FFFF), `pc_init`=1. Expect:
  - 3 `mem_we` pulses, each 1 cycle after `ld_we`
  - `words_loaded`=3, `cpu_pc`=1
  - `cpu_run`=1 exactly 6 cycles after the END_WORD strobe

  Then assert `INITIALIZE` asynchronously mid-load: outputs zero immediately, state IDLE.
- **Fetch forwarding in RUN:** `cpu_fetch_en`=1 with address 0x0005 → `mem_en`=1, `mem_addr`=0x0005, `mem_we`=0 next cycle. `ld_we` pulses in RUN produce no `mem_we`.
- **Overflow:** `ld_we` at `ld_addr`=16384 → no write, `load_error`=1, state HALT, `cpu_run` stays 0.
- **Halt and reload:** in RUN, `cpu_halt` → `cpu_run`=0 next cycle. `start` → `needed`=1. Reload of 2 words gives `words_loaded`=2, `load_error` cleared.
- **Simultaneous events:**
  - `cpu_halt` and `start` in the same RUN cycle → HALT, then LOAD one cycle later.
  - END_WORD at address 16384 → HALT with `load_error`=1.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared types and defaults for the boot sequencer and its instruction-memory port mux.
package boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_HALT  = 3'd4
    } boot_state_t;

    // One-hot owner of the single instruction-memory port.
    typedef enum logic [1:0] {
        OWN_NONE   = 2'b00,
        OWN_LOADER = 2'b01,
        OWN_CPU    = 2'b10
    } port_owner_t;

    localparam logic [31:0] END_WORD      = 32'hFFFF_FFFF;
    localparam int          DEF_ADDR_W    = 16;
    localparam int          DEF_MEM_DEPTH = 16384;

endpackage

// File: rtl/imem_port_mux.sv
// Registered 2:1 selector giving the instruction-memory port to the loader or to CPU fetch.
module imem_port_mux
    import boot_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        owner,
    input  logic              ld_wr,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic              fetch_en,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata
);

    logic              en_s;
    logic              we_s;
    logic [ADDR_W-1:0] addr_s;
    logic [31:0]       wdata_s;

    // Select the request of the current owner; an idle port drives zeros.
    always_comb begin
        en_s    = 1'b0;
        we_s    = 1'b0;
        addr_s  = {ADDR_W{1'b0}};
        wdata_s = 32'h0000_0000;
        case (owner)
            OWN_LOADER: begin
                if (ld_wr) begin
                    en_s    = 1'b1;
                    we_s    = 1'b1;
                    addr_s  = ld_addr;
                    wdata_s = ld_data;
                end else begin
                    en_s    = 1'b0;
                    we_s    = 1'b0;
                end
            end
            OWN_CPU: begin
                if (fetch_en) begin
                    en_s   = 1'b1;
                    addr_s = fetch_addr;
                end else begin
                    en_s   = 1'b0;
                end
            end
            default: begin
                en_s = 1'b0;
                we_s = 1'b0;
            end
        endcase
    end

    // Port output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= 32'h0000_0000;
        end else begin
            mem_en    <= en_s;
            mem_we    <= we_s;
            mem_addr  <= addr_s;
            mem_wdata <= wdata_s;
        end
    end

endmodule

// File: rtl/boot_sequencer.sv
// Boot controller: sequences IDLE/LOAD/START/RUN/HALT, owns the instruction-memory
// port and releases the CPU at the latched entry PC once the program image is loaded.
module boot_sequencer
    import boot_pkg::*;
#(
    parameter int          ADDR_W      = DEF_ADDR_W,
    parameter int          MEM_DEPTH   = DEF_MEM_DEPTH,
    parameter logic [31:0] END_WORD    = boot_pkg::END_WORD,
    parameter int          START_DELAY = 4
) (
    input  logic              CLK,
    input  logic              INITIALIZE,
    input  logic              start,
    output logic              needed,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [31:0]       ld_data,
    input  logic [31:0]       pc_init,
    input  logic              cpu_fetch_en,
    input  logic [ADDR_W-1:0] cpu_fetch_addr,
    input  logic              cpu_halt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    output logic [31:0]       cpu_pc,
    output logic [ADDR_W:0]   words_loaded,
    output logic              load_error
);

    localparam logic [ADDR_W:0]    DEPTH_L  = (ADDR_W + 1)'(MEM_DEPTH);
    localparam int                 DLY_W    = (START_DELAY < 1) ? 1 : $clog2(START_DELAY + 1);
    localparam logic [DLY_W-1:0]   DLY_LAST = DLY_W'(START_DELAY);

    boot_state_t       state_r;
    boot_state_t       state_s;
    logic [DLY_W-1:0]  delay_cnt_r;
    logic              in_range_s;
    logic              ld_wr_s;
    logic [1:0]        owner_s;
    logic              needed_r;
    logic              needed_s;
    logic              cpu_run_r;
    logic              cpu_run_s;
    logic              load_error_r;
    logic              load_error_s;
    logic [31:0]       cpu_pc_r;
    logic [31:0]       cpu_pc_s;
    logic [ADDR_W:0]   words_loaded_r;
    logic [ADDR_W:0]   words_loaded_s;

    assign in_range_s = ({1'b0, ld_addr} < DEPTH_L);

    // FSM state register.
    always_ff @(posedge CLK or posedge INITIALIZE) begin
        if (INITIALIZE) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // START dwell counter; counts 0..START_DELAY so the final loader write has retired.
    always_ff @(posedge CLK or posedge INITIALIZE) begin
        if (INITIALIZE) begin
            delay_cnt_r <= {DLY_W{1'b0}};
        end else if (state_r != ST_START) begin
            delay_cnt_r <= {DLY_W{1'b0}};
        end else if (delay_cnt_r != DLY_LAST) begin
            delay_cnt_r <= delay_cnt_r + DLY_W'(1);
        end else begin
            delay_cnt_r <= delay_cnt_r;
        end
    end

    // Next-state logic; an out-of-range strobe beats END_WORD, a halt beats start.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_LOAD;
                else       state_s = ST_IDLE;
            end
            ST_LOAD: begin
                if (ld_we && !in_range_s)           state_s = ST_HALT;
                else if (ld_we && ld_data == END_WORD) state_s = ST_START;
                else                                state_s = ST_LOAD;
            end
            ST_START: begin
                if (delay_cnt_r == DLY_LAST) state_s = ST_RUN;
                else                         state_s = ST_START;
            end
            ST_RUN: begin
                if (cpu_halt) state_s = ST_HALT;
                else          state_s = ST_RUN;
            end
            ST_HALT: begin
                if (start) state_s = ST_LOAD;
                else       state_s = ST_HALT;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Output decode: port owner, status flags and load bookkeeping for the next cycle.
    always_comb begin
        needed_s       = (state_s == ST_LOAD);
        cpu_run_s      = (state_s == ST_RUN);
        ld_wr_s        = (state_r == ST_LOAD) && ld_we && in_range_s;
        words_loaded_s = words_loaded_r;
        load_error_s   = load_error_r;
        cpu_pc_s       = cpu_pc_r;
        case (state_r)
            ST_LOAD: owner_s = OWN_LOADER;
            ST_RUN:  owner_s = OWN_CPU;
            default: owner_s = OWN_NONE;
        endcase
        if ((state_r == ST_IDLE || state_r == ST_HALT) && state_s == ST_LOAD) begin
            words_loaded_s = {(ADDR_W + 1){1'b0}};
            load_error_s   = 1'b0;
        end else if (state_r == ST_LOAD && ld_we) begin
            if (!in_range_s) begin
                load_error_s = 1'b1;
            end else begin
                if (words_loaded_r != DEPTH_L) begin
                    words_loaded_s = words_loaded_r + (ADDR_W + 1)'(1);
                end else begin
                    words_loaded_s = words_loaded_r;
                end
                if (state_s == ST_START) begin
                    cpu_pc_s = pc_init;
                end else begin
                    cpu_pc_s = cpu_pc_r;
                end
            end
        end else begin
            load_error_s = load_error_r;
        end
    end

    // Status output registers.
    always_ff @(posedge CLK or posedge INITIALIZE) begin
        if (INITIALIZE) begin
            needed_r       <= 1'b0;
            cpu_run_r      <= 1'b0;
            load_error_r   <= 1'b0;
            cpu_pc_r       <= 32'h0000_0000;
            words_loaded_r <= {(ADDR_W + 1){1'b0}};
        end else begin
            needed_r       <= needed_s;
            cpu_run_r      <= cpu_run_s;
            load_error_r   <= load_error_s;
            cpu_pc_r       <= cpu_pc_s;
            words_loaded_r <= words_loaded_s;
        end
    end

    assign needed       = needed_r;
    assign cpu_run      = cpu_run_r;
    assign load_error   = load_error_r;
    assign cpu_pc       = cpu_pc_r;
    assign words_loaded = words_loaded_r;

    imem_port_mux #(
        .ADDR_W (ADDR_W)
    ) u_port_mux (
        .clk        (CLK),
        .rst        (INITIALIZE),
        .owner      (owner_s),
        .ld_wr      (ld_wr_s),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .fetch_en   (cpu_fetch_en),
        .fetch_addr (cpu_fetch_addr),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata)
    );

endmodule

// File: tb/tb_boot_sequencer.sv
// Scoreboarded random bench for boot_sequencer: expected memory-port transactions are
// queued at stimulus time and popped by an independent monitor.
module tb_boot_sequencer;

    localparam int          ADDR_W      = 16;
    localparam int          MEM_DEPTH   = 16384;
    localparam int          START_DELAY = 4;
    localparam logic [31:0] END_W       = 32'hFFFF_FFFF;

    logic              CLK = 1'b0;
    logic              INITIALIZE = 1'b0;
    logic              start = 1'b0;
    logic              needed;
    logic              ld_we = 1'b0;
    logic [ADDR_W-1:0] ld_addr = 16'h0000;
    logic [31:0]       ld_data = 32'h0;
    logic [31:0]       pc_init = 32'h0;
    logic              cpu_fetch_en = 1'b0;
    logic [ADDR_W-1:0] cpu_fetch_addr = 16'h0000;
    logic              cpu_halt = 1'b0;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_run;
    logic [31:0]       cpu_pc;
    logic [ADDR_W:0]   words_loaded;
    logic              load_error;

    boot_sequencer #(
        .ADDR_W(ADDR_W), .MEM_DEPTH(MEM_DEPTH), .END_WORD(END_W), .START_DELAY(START_DELAY)
    ) dut (
        .CLK(CLK), .INITIALIZE(INITIALIZE), .start(start), .needed(needed),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .pc_init(pc_init),
        .cpu_fetch_en(cpu_fetch_en), .cpu_fetch_addr(cpu_fetch_addr), .cpu_halt(cpu_halt),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_run(cpu_run), .cpu_pc(cpu_pc), .words_loaded(words_loaded), .load_error(load_error)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int                cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    // Monitor: every enabled port cycle must match the oldest queued expectation.
    always @(negedge CLK) begin
        if (!INITIALIZE) begin
            if (mem_en) begin
                if (q.size() == 0) begin
                    chk("mem_unexpected", 64'(mem_addr), 64'hDEAD);
                end else begin
                    mon_e = q.pop_front();
                    chk("mem_we", 64'(mem_we), 64'(mon_e.we));
                    chk("mem_addr", 64'(mem_addr), 64'(mon_e.addr));
                    chk("mem_wdata", 64'(mem_wdata), 64'(mon_e.data));
                    chk("mem_cycle", 64'(cyc), 64'(mon_e.cyc));
                end
            end else if (mem_we) begin
                chk("we_without_en", 64'(mem_we), 64'd0);
            end
        end
    end

    task automatic step();
        @(negedge CLK);
    endtask

    function automatic logic [31:0] rnd_word();
        logic [31:0] w;
        w = $urandom;
        if (w == END_W) w = 32'h0000_0000;
        return w;
    endfunction

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        ld_we   = 1'b1;
        ld_addr = a;
        ld_data = d;
        if (int'(a) < MEM_DEPTH) q.push_back('{we: 1'b1, addr: a, data: d, cyc: cyc + 1});
        step();
        ld_we = 1'b0;
    endtask

    task automatic pulse_start_chk();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_needed", 64'(needed), 64'd1);
        chk("start_err_clr", 64'(load_error), 64'd0);
        chk("start_words_clr", 64'(words_loaded), 64'd0);
        chk("start_run", 64'(cpu_run), 64'd0);
    endtask

    task automatic load_image(input int n, input logic [31:0] pc, input bit seq, output int end_c);
        int gaps;
        logic [ADDR_W-1:0] a;
        logic [31:0] d;
        pc_init = pc;
        end_c = 0;
        for (int i = 0; i < n; i++) begin
            gaps = seq ? 0 : int'($urandom_range(2, 0));
            repeat (gaps) begin
                cpu_fetch_en   = 1'($urandom_range(1, 0));
                cpu_fetch_addr = ADDR_W'($urandom);
                step();
            end
            cpu_fetch_en = 1'b0;
            a = seq ? ADDR_W'(i) : ADDR_W'($urandom_range(MEM_DEPTH - 1, 0));
            d = (i == n - 1) ? END_W : rnd_word();
            if (i == n - 1) end_c = cyc;
            write_word(a, d);
        end
    endtask

    task automatic expect_run(input int end_c, input int n, input logic [31:0] pc);
        int w;
        w = 0;
        while (cpu_run !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        chk("run_latency", 64'(cyc - end_c), 64'(START_DELAY + 2));
        chk("words_loaded", 64'(words_loaded), 64'((n < MEM_DEPTH) ? n : MEM_DEPTH));
        chk("cpu_pc", 64'(cpu_pc), 64'(pc));
        chk("run_err", 64'(load_error), 64'd0);
        chk("run_needed", 64'(needed), 64'd0);
    endtask

    task automatic run_fetches(input int k, input int n_words);
        for (int i = 0; i < k; i++) begin
            cpu_fetch_en   = 1'($urandom_range(1, 0));
            cpu_fetch_addr = ADDR_W'($urandom);
            if (cpu_fetch_en) q.push_back('{we: 1'b0, addr: cpu_fetch_addr, data: 32'h0, cyc: cyc + 1});
            ld_we   = 1'($urandom_range(1, 0));
            ld_addr = ADDR_W'($urandom_range(MEM_DEPTH - 1, 0));
            ld_data = rnd_word();
            step();
        end
        cpu_fetch_en = 1'b0;
        ld_we = 1'b0;
        step();
        chk("run_words_kept", 64'(words_loaded), 64'(n_words));
        chk("run_still", 64'(cpu_run), 64'd1);
    endtask

    task automatic do_halt(input bit with_start);
        cpu_halt = 1'b1;
        start    = with_start;
        step();
        cpu_halt = 1'b0;
        chk("halt_run", 64'(cpu_run), 64'd0);
        chk("halt_needed", 64'(needed), 64'd0);
        if (with_start) begin
            step();
            start = 1'b0;
            chk("reload_needed", 64'(needed), 64'd1);
        end
    endtask

    task automatic overflow(input int k, input logic [ADDR_W-1:0] bad, input logic [31:0] d);
        for (int j = 0; j < k; j++) write_word(ADDR_W'($urandom_range(MEM_DEPTH - 1, 0)), rnd_word());
        write_word(bad, d);
        chk("ovf_err", 64'(load_error), 64'd1);
        chk("ovf_needed", 64'(needed), 64'd0);
        chk("ovf_run", 64'(cpu_run), 64'd0);
        chk("ovf_words", 64'(words_loaded), 64'(k));
        repeat (3) begin
            ld_we   = 1'b1;
            ld_addr = ADDR_W'($urandom_range(MEM_DEPTH - 1, 0));
            ld_data = rnd_word();
            step();
        end
        ld_we = 1'b0;
        chk("halt_run_stays", 64'(cpu_run), 64'd0);
    endtask

    task automatic async_reset_check();
        ld_we        = 1'b1;
        ld_addr      = ADDR_W'($urandom_range(MEM_DEPTH - 1, 0));
        ld_data      = rnd_word();
        cpu_fetch_en = 1'b1;
        #2;
        INITIALIZE = 1'b1;
        #1;
        chk("rst_needed", 64'(needed), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_cpu_run", 64'(cpu_run), 64'd0);
        chk("rst_cpu_pc", 64'(cpu_pc), 64'd0);
        chk("rst_words", 64'(words_loaded), 64'd0);
        chk("rst_err", 64'(load_error), 64'd0);
        ld_we = 1'b0;
        cpu_fetch_en = 1'b0;
        step();
        INITIALIZE = 1'b0;
        ld_we = 1'b1;
        step();
        ld_we = 1'b0;
        step();
        chk("idle_needed", 64'(needed), 64'd0);
        chk("idle_run", 64'(cpu_run), 64'd0);
        chk("idle_queue", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int end_c;
        int n;
        int kind;
        bit in_load;
        logic [31:0] pc;

        #1 INITIALIZE = 1'b1;
        step();
        step();
        chk("init_needed", 64'(needed), 64'd0);
        chk("init_mem_en", 64'(mem_en), 64'd0);
        chk("init_cpu_run", 64'(cpu_run), 64'd0);
        chk("init_cpu_pc", 64'(cpu_pc), 64'd0);
        chk("init_words", 64'(words_loaded), 64'd0);
        chk("init_err", 64'(load_error), 64'd0);
        INITIALIZE = 1'b0;
        step();
        chk("idle_hold", 64'(needed), 64'd0);

        pulse_start_chk();
        load_image(3, 32'h0000_0001, 1'b1, end_c);
        expect_run(end_c, 3, 32'h0000_0001);

        cpu_fetch_en   = 1'b1;
        cpu_fetch_addr = 16'h0005;
        q.push_back('{we: 1'b0, addr: 16'h0005, data: 32'h0, cyc: cyc + 1});
        step();
        cpu_fetch_en = 1'b0;
        run_fetches(10, 3);

        do_halt(1'b0);
        pulse_start_chk();
        pc = $urandom;
        load_image(2, pc, 1'b0, end_c);
        expect_run(end_c, 2, pc);
        do_halt(1'b1);

        overflow(0, 16'(MEM_DEPTH), END_W);
        pulse_start_chk();
        pc = $urandom;
        load_image(2, pc, 1'b0, end_c);
        expect_run(end_c, 2, pc);
        async_reset_check();

        pulse_start_chk();
        write_word(ADDR_W'($urandom_range(MEM_DEPTH - 1, 0)), rnd_word());
        write_word(ADDR_W'($urandom_range(MEM_DEPTH - 1, 0)), rnd_word());
        async_reset_check();

        in_load = 1'b0;
        for (int r = 0; r < 8; r++) begin
            kind = int'($urandom_range(2, 0));
            if (!in_load) pulse_start_chk();
            in_load = 1'b0;
            if (kind == 0) begin
                overflow(int'($urandom_range(3, 0)), ADDR_W'($urandom_range(65535, MEM_DEPTH)),
                         ($urandom_range(1, 0) == 1) ? END_W : rnd_word());
            end else begin
                n  = int'($urandom_range(8, 1));
                pc = $urandom;
                load_image(n, pc, 1'b0, end_c);
                expect_run(end_c, n, pc);
                run_fetches(int'($urandom_range(6, 1)), n);
                do_halt(kind == 2);
                in_load = (kind == 2);
            end
        end

        if (!in_load) pulse_start_chk();
        pc = $urandom;
        pc_init = pc;
        for (int i = 0; i < MEM_DEPTH + 2; i++) begin
            if (i == MEM_DEPTH + 1) end_c = cyc;
            write_word(ADDR_W'(i % MEM_DEPTH), (i == MEM_DEPTH + 1) ? END_W : rnd_word());
        end
        expect_run(end_c, MEM_DEPTH + 2, pc);

        step();
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
